// File: rtl/pbus_arb_pkg.sv
// Shared definitions for the two-master peripheral-bus arbiter.
package pbus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_t;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  localparam int TIMEOUT_DEF = 15;

endpackage

// File: rtl/pbus_arb_pick.sv
// Combinational two-request picker.
// PBUS_ARB_RR_EN defined: round-robin on contention (grant != last_gnt).
// PBUS_ARB_RR_EN undefined: fixed priority, m0 always wins.
module pbus_arb_pick
  import pbus_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic       gnt,
  output logic       valid
);

`ifndef PBUS_ARB_RR_EN
  // Grant history plays no part in fixed-priority arbitration.
  logic unused_last_gnt;
  assign unused_last_gnt = last_gnt;
`endif

  // Winner selection: a lone requester always wins; contention per build mode.
  always_comb begin
    valid = |req;
    gnt   = M0;
    if (req == 2'b10) begin
      gnt = M1;
    end else if (req == 2'b11) begin
`ifdef PBUS_ARB_RR_EN
      gnt = ~last_gnt;
`else
      gnt = M0;
`endif
    end
  end

endmodule

// File: rtl/pbus_arb.sv
// pbus_arb: two-master arbiter / sequencer for the 16-bit peripheral bus.
// One access at a time: IDLE -> ACCESS (strobes out, wait i_rdy or watchdog)
// -> RESP (one-cycle ack) -> IDLE. Optional round-robin via PBUS_ARB_RR_EN.
module pbus_arb
  import pbus_arb_pkg::*;
#(
  parameter int AW      = 2,
  parameter int TIMEOUT = TIMEOUT_DEF
)(
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_m0_req,
  input  logic          i_m0_we,
  input  logic [AW-1:0] i_m0_addr,
  input  logic [15:0]   i_m0_wdata,
  output logic          o_m0_ack,
  output logic          o_m0_err,
  output logic [15:0]   o_m0_rdata,
  input  logic          i_m1_req,
  input  logic          i_m1_we,
  input  logic [AW-1:0] i_m1_addr,
  input  logic [15:0]   i_m1_wdata,
  output logic          o_m1_ack,
  output logic          o_m1_err,
  output logic [15:0]   o_m1_rdata,
  output logic          o_sel,
  output logic          o_we,
  output logic          o_re,
  output logic [AW-1:0] o_addr,
  output logic [15:0]   o_wdata,
  input  logic [15:0]   i_rdata,
  input  logic          i_rdy
);

  localparam int             CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

  state_t        state;
  logic          last_gnt;
  logic          gnt_idx;
  logic          cmd_we;
  logic [CW-1:0] cnt;

  logic          pick_gnt;
  logic          pick_vld;
  logic          nxt_we;
  logic [AW-1:0] nxt_addr;
  logic [15:0]   nxt_wdata;
  logic [15:0]   rd_cap;

  pbus_arb_pick u_pick (
    .req      ({i_m1_req, i_m0_req}),
    .last_gnt (last_gnt),
    .gnt      (pick_gnt),
    .valid    (pick_vld)
  );

  assign nxt_we    = (pick_gnt == M1) ? i_m1_we    : i_m0_we;
  assign nxt_addr  = (pick_gnt == M1) ? i_m1_addr  : i_m0_addr;
  assign nxt_wdata = (pick_gnt == M1) ? i_m1_wdata : i_m0_wdata;

  // Writes and aborted accesses return zero data.
  assign rd_cap = (i_rdy && !cmd_we) ? i_rdata : '0;

  // Sequencer FSM with registered bus strobes and master responses.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      last_gnt   <= M1;
      gnt_idx    <= M0;
      cmd_we     <= 1'b0;
      cnt        <= '0;
      o_sel      <= 1'b0;
      o_we       <= 1'b0;
      o_re       <= 1'b0;
      o_addr     <= '0;
      o_wdata    <= '0;
      o_m0_ack   <= 1'b0;
      o_m0_err   <= 1'b0;
      o_m0_rdata <= '0;
      o_m1_ack   <= 1'b0;
      o_m1_err   <= 1'b0;
      o_m1_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            state    <= ACCESS;
            gnt_idx  <= pick_gnt;
            last_gnt <= pick_gnt;
            cmd_we   <= nxt_we;
            o_addr   <= nxt_addr;
            o_wdata  <= nxt_wdata;
            cnt      <= '0;
            o_sel    <= 1'b1;
            o_we     <= nxt_we;
            o_re     <= ~nxt_we;
          end
        end
        ACCESS: begin
          // Ready wins over watchdog expiry on the same edge.
          if (i_rdy || cnt == CNT_LAST) begin
            state <= RESP;
            o_sel <= 1'b0;
            o_we  <= 1'b0;
            o_re  <= 1'b0;
            if (gnt_idx == M1) begin
              o_m1_ack   <= 1'b1;
              o_m1_err   <= ~i_rdy;
              o_m1_rdata <= rd_cap;
            end else begin
              o_m0_ack   <= 1'b1;
              o_m0_err   <= ~i_rdy;
              o_m0_rdata <= rd_cap;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          state      <= IDLE;
          o_m0_ack   <= 1'b0;
          o_m0_err   <= 1'b0;
          o_m0_rdata <= '0;
          o_m1_ack   <= 1'b0;
          o_m1_err   <= 1'b0;
          o_m1_rdata <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/pbus_arb.md
# pbus_arb

Two-master arbiter and sequencer for the 16-bit peripheral bus that drives the parallel I/O port and similar simple slaves. It accepts single read/write requests from two masters (CPU load/store unit and a DMA/debug engine), grants one at a time, drives the slave-side select/write/read strobes, waits for slave ready, and returns a registered acknowledge with read data. A cycle-count watchdog terminates accesses to a slave that never asserts ready.

## Interface
- AW, 2, slave address width
- TIMEOUT, 15, max cycles in ACCESS before abort; must be 1..255
- i_clk  in  1  clock, all state on rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_m0_req / i_m1_req  in  1  request, held high until ack
- i_m0_we / i_m1_we  in  1  1 = write, 0 = read; valid with req
- i_m0_addr / i_m1_addr  in  AW  slave address
- i_m0_wdata / i_m1_wdata  in  16  write data
- o_m0_ack / o_m1_ack  out  1  one-cycle completion pulse
- o_m0_err / o_m1_err  out  1  timeout flag, valid only with ack
- o_m0_rdata / o_m1_rdata  out  16  read data, valid only with ack
- o_sel  out  1  slave select
- o_we / o_re  out  1  write / read strobe, mutually exclusive
- o_addr  out  AW  slave address
- o_wdata  out  16  slave write data
- i_rdata  in  16  slave read data, combinational from slave
- i_rdy  in  1  slave ready

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: if any req high at edge, pick winner, latch its we/addr/wdata into command register, record grant index, load timeout counter with 0, go ACCESS. Else stay.
- ACCESS: o_sel=1, o_we=cmd_we, o_re=!cmd_we, o_addr/o_wdata from command register. At edge with i_rdy=1: capture i_rdata (reads only; writes capture 0), err=0, go RESP. Else increment counter; at edge where counter==TIMEOUT-1 and i_rdy=0: capture rdata=0, err=1, go RESP.
- RESP: o_sel/o_we/o_re=0; granted master's ack=1, its rdata/err driven from capture register; other master's ack/err=0, rdata=0. Always go IDLE next edge.
- Masters drop or re-present req in the cycle after ack; a req still high in IDLE starts a new transaction.
- Non-granted master's req is ignored until IDLE; no queuing beyond the req level.
- Grant pointer last_gnt updated only on IDLE→ACCESS.

## Timing
- Reset (async assert): state IDLE, all outputs 0, last_gnt=1, counter 0, capture register 0. In-flight access dropped, no ack issued.
- Zero-wait slave (i_rdy=o_sel): req sampled at edge E0 → o_sel high E0..E1 → ack high E1..E2 → IDLE at E2. Three cycles per transfer; sustained throughput one access per 3 cycles.
- Write commits at slave on the edge where o_sel&o_we&i_rdy; exactly one such edge per write.
- Timeout: ack with err at TIMEOUT+1 cycles after grant edge; i_rdy arriving on the same edge as expiry counts as success (err=0).
- Simultaneous req in IDLE: resolved per Configuration; loser served on its next IDLE sample if still requesting.

## Configuration
- PBUS_ARB_RR_EN defined: round-robin; on simultaneous req grant master != last_gnt. First contention after reset goes to m0.
- Undefined: fixed priority, m0 always wins; last_gnt still maintained but unused. m1 may starve.

## Structure
- Shared package pbus_arb_pkg: state encoding (IDLE=2'b00, ACCESS=2'b01, RESP=2'b10), master index constants M0=1'b0/M1=1'b1, default TIMEOUT.
- One sub-module pbus_arb_pick: combinational two-request picker (inputs req[1:0], last_gnt, output gnt index, valid); contains the PBUS_ARB_RR_EN ifdef.
- Counter width $clog2(TIMEOUT+1).

## Test plan
- m0 read addr 2'b10, zero-wait slave returning 16'h000A → o_m0_ack one cycle at E1..E2, o_m0_rdata=16'h000A, err=0, o_m1_ack never high.
- m1 write addr 0 data 16'h1235 → exactly one edge with o_sel&o_we, o_wdata=16'h1235; subsequent read addr 0 returns 16'h0005 from a 4-bit slave.
- Both req held high for 4 transfers, RR_EN defined → grant order m0,m1,m0,m1; undefined → m0 ×4.
- Slave i_rdy tied 0, TIMEOUT=15 → ack with err=1, rdata=0 at 16 cycles after grant; o_sel drops in RESP.
- i_rst_n pulsed low mid-ACCESS → o_sel, o_we, o_re, all acks 0 immediately; after release, next req granted to m0, no stale ack.
- i_rdy delayed 3 cycles then high → ack 2+3 cycles after grant edge, err=0.
